sipo_rx: RTL and testbench



---
 rtl/sipo_rx.sv | 143 ++++++++++++++
 tb/tb_sipo_rx.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out receiver: MSB-first bit stream in, N-bit words out on valid/ready.
// Optional even-parity trailer bit per frame when SIPO_PARITY_EN is defined.
module sipo_rx #(
    parameter int N = 10
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         SI,
    input  logic         SI_VALID,
    output logic         SI_READY,
    input  logic         ABORT,
    output logic [N-1:0] PO,
    output logic         PO_VALID,
    input  logic         PO_READY,
    output logic         PERR
);

    localparam int CW = $clog2(N + 2);
`ifdef SIPO_PARITY_EN
    localparam int LAST = N;
`else
    localparam int LAST = N - 1;
`endif

    typedef enum logic {
        FILL,
        HOLD
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   sr_q, sr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   po_q, po_d;
    logic           po_valid_q, po_valid_d;
`ifdef SIPO_PARITY_EN
    logic           perr_q, perr_d;
    logic           par_q, par_d;
`endif

    logic           slot_free;
    logic           accept;
    logic           final_bit;
    logic [N-1:0]   shifted;

    assign slot_free = !po_valid_q || PO_READY;
    assign accept    = SI_VALID && (state_q == FILL);
    assign final_bit = (cnt_q == CW'(LAST));
    assign shifted   = {sr_q[N-2:0], SI};

    // NOTE: every variable gets its hold value first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        po_d       = po_q;
        po_valid_d = po_valid_q && !PO_READY;
`ifdef SIPO_PARITY_EN
        perr_d     = perr_q;
        par_d      = par_q;
`endif

        if (ABORT) begin
            // Only the serial side is discarded; the output handshake above still runs.
            sr_d    = '0;
            cnt_d   = '0;
            state_d = FILL;
        end else if (state_q == HOLD) begin
            if (slot_free) begin
                po_d       = sr_q;
                po_valid_d = 1'b1;
                cnt_d      = '0;
                state_d    = FILL;
`ifdef SIPO_PARITY_EN
                perr_d     = (^sr_q) ^ par_q;
`endif
            end
        end else if (accept) begin
            if (final_bit) begin
`ifdef SIPO_PARITY_EN
                // Parity trailer: SR already holds the full data word.
                if (slot_free) begin
                    po_d       = sr_q;
                    perr_d     = (^sr_q) ^ SI;
                    po_valid_d = 1'b1;
                    cnt_d      = '0;
                end else begin
                    par_d   = SI;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = HOLD;
                end
`else
                if (slot_free) begin
                    po_d       = shifted;
                    po_valid_d = 1'b1;
                    cnt_d      = '0;
                end else begin
                    sr_d    = shifted;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = HOLD;
                end
`endif
            end else begin
                sr_d  = shifted;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= FILL;
            sr_q       <= '0;
            cnt_q      <= '0;
            po_q       <= '0;
            po_valid_q <= 1'b0;
`ifdef SIPO_PARITY_EN
            perr_q     <= 1'b0;
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            po_q       <= po_d;
            po_valid_q <= po_valid_d;
`ifdef SIPO_PARITY_EN
            perr_q     <= perr_d;
            par_q      <= par_d;
`endif
        end
    end

    assign SI_READY = (state_q == FILL);
    assign PO       = po_q;
    assign PO_VALID = po_valid_q;
`ifdef SIPO_PARITY_EN
    assign PERR     = perr_q;
`else
    assign PERR     = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_rx.sv
// Self-checking bench for sipo_rx (N=10): vector table plus hand-written corner sequences.
// Parity checks run only when SIPO_PARITY_EN is defined.
module tb_sipo_rx;

    localparam int N = 10;

    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic         SI = 1'b0;
    logic         SI_VALID = 1'b0;
    logic         SI_READY;
    logic         ABORT = 1'b0;
    logic [N-1:0] PO;
    logic         PO_VALID;
    logic         PO_READY = 1'b0;
    logic         PERR;

    int n_checks = 0;
    int n_fail   = 0;

    sipo_rx #(.N(N)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .SI       (SI),
        .SI_VALID (SI_VALID),
        .SI_READY (SI_READY),
        .ABORT    (ABORT),
        .PO       (PO),
        .PO_VALID (PO_VALID),
        .PO_READY (PO_READY),
        .PERR     (PERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string        name;
        logic         rst;
        logic         si;
        logic         si_valid;
        logic         abort;
        logic         po_ready;
        logic         exp_si_ready;
        logic         exp_po_valid;
        logic [N-1:0] exp_po;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(input string nm, input logic rst, input logic si, input logic sv,
                       input logic ab, input logic rdy, input logic e_rdy,
                       input logic e_vld, input logic [N-1:0] e_po);
        vec_t v;
        v.name = nm; v.rst = rst; v.si = si; v.si_valid = sv; v.abort = ab;
        v.po_ready = rdy; v.exp_si_ready = e_rdy; v.exp_po_valid = e_vld; v.exp_po = e_po;
        vq.push_back(v);
    endtask

    // Drive one cycle of inputs, clock it, and leave time 1 unit past the edge for sampling.
    task automatic cycle(input logic rst, input logic si, input logic sv,
                         input logic ab, input logic rdy);
        RESET = rst; SI = si; SI_VALID = sv; ABORT = ab; PO_READY = rdy;
        @(posedge CLK);
        #1;
    endtask

    // Sends a full word MSB first; flags any PO_VALID seen before the last bit.
    task automatic send_word(input logic [N-1:0] w, input logic rdy, output logic early);
        early = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            cycle(1'b0, w[i], 1'b1, 1'b0, rdy);
            if (i != 0 && PO_VALID) early = 1'b1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         early;
        logic [N-1:0] w;

`ifndef SIPO_PARITY_EN
        // Test 1: continuous word with the consumer always ready.
        w = 10'h2CE;
        add("t1_reset", 1, 0, 0, 0, 1, 1, 0, 10'h000);
        for (int i = N - 1; i >= 0; i--)
            add("t1_bit", 0, w[i], 1, 0, 1, 1, (i == 0), (i == 0) ? 10'h2CE : 10'h000);
        add("t1_after", 0, 0, 0, 0, 1, 1, 0, 10'h2CE);

        // Test 2: backpressure, second word parks in HOLD.
        for (int i = N - 1; i >= 0; i--)
            add("t2_w1", 0, 1'b1, 1, 0, 0, 1, (i == 0), (i == 0) ? 10'h3FF : 10'h2CE);
        w = 10'h155;
        for (int i = N - 1; i >= 0; i--)
            add("t2_w2", 0, w[i], 1, 0, 0, (i != 0), 1, 10'h3FF);
        add("t2_hold", 0, 0, 1, 0, 0, 0, 1, 10'h3FF);
        add("t2_pulse", 0, 1, 1, 0, 1, 1, 1, 10'h155);
        add("t2_keep", 0, 0, 0, 0, 0, 1, 1, 10'h155);
        add("t2_take", 0, 0, 0, 0, 1, 1, 0, 10'h155);

        // Test 3: abort drops the partial word and the bit sent with it.
        for (int i = 0; i < 4; i++)
            add("t3_part", 0, 1, 1, 0, 1, 1, 0, 10'h155);
        add("t3_abort", 0, 1, 1, 1, 1, 1, 0, 10'h155);
        w = 10'h001;
        for (int i = N - 1; i >= 0; i--)
            add("t3_word", 0, w[i], 1, 0, 1, 1, (i == 0), (i == 0) ? 10'h001 : 10'h155);
        add("t3_after", 0, 0, 0, 0, 1, 1, 0, 10'h001);

        foreach (vq[k]) begin
            cycle(vq[k].rst, vq[k].si, vq[k].si_valid, vq[k].abort, vq[k].po_ready);
            check({vq[k].name, "_si_ready"}, SI_READY, vq[k].exp_si_ready);
            check({vq[k].name, "_po_valid"}, PO_VALID, vq[k].exp_po_valid);
            check({vq[k].name, "_po"}, PO, vq[k].exp_po);
            check({vq[k].name, "_perr"}, PERR, 1'b0);
        end

        // Test 4: reset mid-word while a word is pending on PO.
        send_word(10'h2CE, 1'b0, early);
        check("t4_load_valid", PO_VALID, 1'b1);
        check("t4_load_po", PO, 10'h2CE);
        w = 10'h055;
        for (int i = 6; i >= 0; i--)
            cycle(1'b0, w[i], 1'b1, 1'b0, 1'b0);
        check("t4_pending_po", PO, 10'h2CE);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("t4_rst_po", PO, 10'h000);
        check("t4_rst_valid", PO_VALID, 1'b0);
        check("t4_rst_si_ready", SI_READY, 1'b1);
        send_word(10'h200, 1'b1, early);
        check("t4_no_early", early, 1'b0);
        check("t4_word_valid", PO_VALID, 1'b1);
        check("t4_word_po", PO, 10'h200);

        // Test 5: random gaps between bits leave the frame intact.
        w = 10'h2CE;
        early = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            cycle(1'b0, w[i], 1'b1, 1'b0, 1'b1);
            if (i != 0) begin
                if (PO_VALID) early = 1'b1;
                for (int g = $urandom_range(3, 1); g > 0; g--) begin
                    cycle(1'b0, ~w[i], 1'b0, 1'b0, 1'b1);
                    if (PO_VALID) early = 1'b1;
                end
            end
        end
        check("t5_no_early", early, 1'b0);
        check("t5_valid", PO_VALID, 1'b1);
        check("t5_po", PO, 10'h2CE);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t5_consumed", PO_VALID, 1'b0);
`else
        // Test 6: 11-bit frames with an even-parity trailer.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("p_rst_valid", PO_VALID, 1'b0);
        check("p_rst_perr", PERR, 1'b0);
        send_word(10'h2CE, 1'b1, early);
        check("p_need_11th", PO_VALID, 1'b0);
        check("p_ready_11th", SI_READY, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("p_good_valid", PO_VALID, 1'b1);
        check("p_good_po", PO, 10'h2CE);
        check("p_good_perr", PERR, 1'b0);
        send_word(10'h2CE, 1'b1, early);
        check("p_bad_wait", PO_VALID, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("p_bad_valid", PO_VALID, 1'b1);
        check("p_bad_po", PO, 10'h2CE);
        check("p_bad_perr", PERR, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("p_bad_perr_hold", PERR, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("p_consumed", PO_VALID, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
